traffic_light_monitor: RTL and testbench
========================================

// Module: traffic_light_monitor
// PURPOSE
//  Observes the red/amber/green outputs of the UK traffic-light sequencer and decodes them
//  back into a phase code: 00 red, 01 red+amber, 10 green, 11 amber.
//  Checks that legal phases follow in order and flags illegal lamp combinations.
//  Measures how long each phase lasts and counts completed light cycles.
//  Sits beside the sequencer in the same clk domain as a self-check block for the test bench and for the system.
// PARAMETERS
//  DWELL_W    8   width of the phase dwell counter (saturating)
//  CYC_W      8   width of the completed-cycle counter (wraps)
//  MAX_DWELL  16  max cycles a phase may hold before timeout_err (needs TL_DWELL_CHECK_EN)
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        asynchronous, active-high reset
//  red          in   1        red lamp, synchronous to clk
//  amber        in   1        amber lamp
//  green        in   1        green lamp
//  phase        out  2        decoded phase; valid only when phase_valid=1
//  phase_valid  out  1        monitor is locked to a legal phase
//  dwell        out  DWELL_W  cycles the current phase has been held, including the current cycle
//  cycle_count  out  CYC_W    number of amber->red transitions seen; wraps at 2^CYC_W
//  seq_err      out  1        1-cycle pulse: legal phase arrived out of order
//  illegal_err  out  1        1-cycle pulse: illegal lamp combination
//  timeout_err  out  1        1-cycle pulse: phase held longer than MAX_DWELL
//  err_count    out  8        seq_err + illegal_err + timeout_err pulses; saturates at 255
// BEHAVIOUR
//  - Reset values: all outputs 0, FSM in SYNC. Reset is asynchronous and takes priority at any time.
//  - Decode {red,amber,green}: 100->00, 110->01, 001->10, 010->11. The other 4 codes are illegal.
//  - Raw inputs are decoded combinationally; all outputs are registered.
//    Latency: 1 clk, so lamps at edge N are reflected in the outputs after edge N.
//  - FSM SYNC:
//    - Legal code: phase<=code, phase_valid<=1, dwell<=1, go TRACK. No error.
//    - Illegal code: illegal_err pulses and the FSM stays in SYNC.
//  - FSM TRACK:
//    - code==phase: dwell<=dwell+1, saturating at 2^DWELL_W-1.
//    - code==phase+1 mod 4: phase<=code, dwell<=1. If old phase was 11 and new is 00, cycle_count++ (wraps).
//    - Other legal code: seq_err pulses; resync with phase<=code, dwell<=1; cycle_count unchanged.
//    - Illegal code: illegal_err pulses; phase_valid<=0; phase keeps its last value; dwell<=0; go SYNC.
//  - At most one of seq_err/illegal_err is asserted in a cycle. err_count increments once per error event.
//  - If timeout_err and another error occur in the same cycle, err_count still increments by 1 only.
//  - A timeout does not change phase or the FSM state.
//  - Reset asserted mid-cycle clears all counters; after release the FSM relocks from SYNC.
// CONFIGURATION
//  TL_DWELL_CHECK_EN defined:
//    - In TRACK, timeout_err pulses exactly once per phase, in the cycle where dwell goes
//      from MAX_DWELL to MAX_DWELL+1.
//    - It does not pulse again until the phase changes.
//  TL_DWELL_CHECK_EN undefined: timeout_err is tied to 0 and no compare logic is built.
// TESTING
//  1. Reset; drive 100x3, 110x1, 001x4, 010x1, 100x1
//     -> phase 00,01,10,11,00; phase_valid=1 from the 1st edge; cycle_count=1; no errors.
//  2. In TRACK at red, drive 001 -> seq_err one pulse, phase=10, dwell=1, err_count=1.
//  3. Drive 111 while in TRACK
//     -> illegal_err pulse, phase_valid=0; next 110 relocks with phase=01 and no seq_err.
//  4. With TL_DWELL_CHECK_EN and MAX_DWELL=16, hold 100 for 20 cycles
//     -> one timeout_err pulse on the 17th cycle, err_count=1.
//     Without the macro -> no pulse.
//  5. Cause 300 alternating seq errors -> err_count saturates at 255.
//     Run 2^CYC_W+1 full cycles -> cycle_count=1.
//  6. Assert rst mid-green for 1 cycle -> all outputs 0 immediately; 010 then relocks with phase=11.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
//   Watches the red/amber/green lamp outputs of the UK traffic-light
//   sequencer and decodes them into a phase code:
//   00 red, 01 red+amber, 10 green, 11 amber.
//   It checks that legal phases follow in order, flags illegal lamp
//   combinations, measures how long each phase lasts, and counts
//   completed light cycles. It runs in the sequencer's clock domain.
//
//   Optional feature: define TL_DWELL_CHECK_EN to build the dwell
//   timeout check. Without it, timeout_err is tied to 0.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   red/amber/green  lamp inputs, synchronous to clk
//   phase        decoded phase; meaningful only while phase_valid=1
//   phase_valid  monitor is locked to a legal phase
//   dwell        cycles the current phase has been held (saturating)
//   cycle_count  amber->red transitions seen (wraps)
//   seq_err      1-cycle pulse: legal phase arrived out of order
//   illegal_err  1-cycle pulse: illegal lamp combination
//   timeout_err  1-cycle pulse: phase held longer than MAX_DWELL
//   err_count    error events seen, saturating at 255
//
// States
//   SYNC  | not locked; waiting for a legal lamp code
//   TRACK | locked; following the phase order and measuring dwell

module traffic_light_monitor #(
    parameter int DWELL_W   = 8,
    parameter int CYC_W     = 8,
    parameter int MAX_DWELL = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               red,
    input  logic               amber,
    input  logic               green,
    output logic [1:0]         phase,
    output logic               phase_valid,
    output logic [DWELL_W-1:0] dwell,
    output logic [CYC_W-1:0]   cycle_count,
    output logic               seq_err,
    output logic               illegal_err,
    output logic               timeout_err,
    output logic [7:0]         err_count
);

    typedef enum logic {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam logic [DWELL_W-1:0] DWELL_MAX = '1;

    state_t             state, state_nx;
    logic               legal;
    logic [1:0]         code;
    logic [1:0]         phase_nx;
    logic               valid_nx;
    logic [DWELL_W-1:0] dwell_nx;
    logic [CYC_W-1:0]   cyc_nx;
    logic               seq_nx;
    logic               ill_nx;
    logic               to_nx;
    logic [7:0]         errc_nx;

    always_comb begin
        legal = 1'b1;
        code  = 2'b00;
        case ({red, amber, green})
            3'b100:  code = 2'b00;
            3'b110:  code = 2'b01;
            3'b001:  code = 2'b10;
            3'b010:  code = 2'b11;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        phase_nx = phase;
        valid_nx = phase_valid;
        dwell_nx = dwell;
        cyc_nx   = cycle_count;
        seq_nx   = 1'b0;
        ill_nx   = 1'b0;
        to_nx    = 1'b0;

        case (state)
            SYNC: begin
                if (legal) begin
                    phase_nx = code;
                    valid_nx = 1'b1;
                    dwell_nx = DWELL_W'(1);
                    state_nx = TRACK;
                end else begin
                    ill_nx = 1'b1;
                end
            end
            TRACK: begin
                if (!legal) begin
                    // Phase keeps its last value so it can still be read
                    // after losing lock; phase_valid tells it is stale.
                    ill_nx   = 1'b1;
                    valid_nx = 1'b0;
                    dwell_nx = '0;
                    state_nx = SYNC;
                end else if (code == phase) begin
                    if (dwell != DWELL_MAX) begin
                        dwell_nx = dwell + DWELL_W'(1);
                    end
`ifdef TL_DWELL_CHECK_EN
                    // dwell passes through MAX_DWELL only once per phase,
                    // so this fires once and never repeats while it saturates.
                    if (dwell == DWELL_W'(MAX_DWELL) && dwell != DWELL_MAX) begin
                        to_nx = 1'b1;
                    end
`endif
                end else begin
                    if (code != phase + 2'd1) begin
                        seq_nx = 1'b1;
                    end else if (phase == 2'b11) begin
                        cyc_nx = cycle_count + CYC_W'(1);
                    end
                    phase_nx = code;
                    dwell_nx = DWELL_W'(1);
                end
            end
            default: state_nx = SYNC;
        endcase

        // Simultaneous errors count as a single event.
        errc_nx = err_count;
        if ((seq_nx || ill_nx || to_nx) && err_count != 8'hFF) begin
            errc_nx = err_count + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SYNC;
            phase       <= 2'b00;
            phase_valid <= 1'b0;
            dwell       <= '0;
            cycle_count <= '0;
            seq_err     <= 1'b0;
            illegal_err <= 1'b0;
            timeout_err <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            state       <= state_nx;
            phase       <= phase_nx;
            phase_valid <= valid_nx;
            dwell       <= dwell_nx;
            cycle_count <= cyc_nx;
            seq_err     <= seq_nx;
            illegal_err <= ill_nx;
            timeout_err <= to_nx;
            err_count   <= errc_nx;
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
module tb_traffic_light_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] lamps = 3'b000;
    logic [1:0] phase;
    logic       phase_valid;
    logic [7:0] dwell;
    logic [7:0] cycle_count;
    logic       seq_err;
    logic       illegal_err;
    logic       timeout_err;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    traffic_light_monitor #(
        .DWELL_W  (8),
        .CYC_W    (8),
        .MAX_DWELL(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .red        (lamps[2]),
        .amber      (lamps[1]),
        .green      (lamps[0]),
        .phase      (phase),
        .phase_valid(phase_valid),
        .dwell      (dwell),
        .cycle_count(cycle_count),
        .seq_err    (seq_err),
        .illegal_err(illegal_err),
        .timeout_err(timeout_err),
        .err_count  (err_count)
    );

`ifdef TL_DWELL_CHECK_EN
    localparam int TO_EXP = 1;
`else
    localparam int TO_EXP = 0;
`endif

    typedef struct {
        logic [2:0] lamps;
        logic [1:0] phase;
        logic       valid;
        logic [7:0] dwell;
        logic [7:0] cyc;
        logic       seq;
        logic       ill;
        logic [7:0] errc;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [2:0] l);
        lamps = l;
        @(posedge clk);
        #1;
    endtask

    // Reset with the given lamp code already present, released between edges.
    task automatic do_reset(input logic [2:0] l);
        rst   = 1'b1;
        lamps = l;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " phase"},       32'(phase), 0);
        check({tag, " phase_valid"}, 32'(phase_valid), 0);
        check({tag, " dwell"},       32'(dwell), 0);
        check({tag, " cycle_count"}, 32'(cycle_count), 0);
        check({tag, " errs"},        32'({seq_err, illegal_err, timeout_err}), 0);
        check({tag, " err_count"},   32'(err_count), 0);
    endtask

    initial begin
        int to_pulses;
        int to_edge;
        int seq_pulses;

        //            lamps   ph     v     dw    cyc   seq   ill   errc
        vecs[0]  = '{3'b100, 2'b00, 1'b1, 8'd1, 8'd0, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{3'b100, 2'b00, 1'b1, 8'd2, 8'd0, 1'b0, 1'b0, 8'd0};
        vecs[2]  = '{3'b100, 2'b00, 1'b1, 8'd3, 8'd0, 1'b0, 1'b0, 8'd0};
        vecs[3]  = '{3'b110, 2'b01, 1'b1, 8'd1, 8'd0, 1'b0, 1'b0, 8'd0};
        vecs[4]  = '{3'b001, 2'b10, 1'b1, 8'd1, 8'd0, 1'b0, 1'b0, 8'd0};
        vecs[5]  = '{3'b001, 2'b10, 1'b1, 8'd2, 8'd0, 1'b0, 1'b0, 8'd0};
        vecs[6]  = '{3'b001, 2'b10, 1'b1, 8'd3, 8'd0, 1'b0, 1'b0, 8'd0};
        vecs[7]  = '{3'b001, 2'b10, 1'b1, 8'd4, 8'd0, 1'b0, 1'b0, 8'd0};
        vecs[8]  = '{3'b010, 2'b11, 1'b1, 8'd1, 8'd0, 1'b0, 1'b0, 8'd0};
        vecs[9]  = '{3'b100, 2'b00, 1'b1, 8'd1, 8'd1, 1'b0, 1'b0, 8'd0};
        vecs[10] = '{3'b001, 2'b10, 1'b1, 8'd1, 8'd1, 1'b1, 1'b0, 8'd1};
        vecs[11] = '{3'b010, 2'b11, 1'b1, 8'd1, 8'd1, 1'b0, 1'b0, 8'd1};
        vecs[12] = '{3'b111, 2'b11, 1'b0, 8'd0, 8'd1, 1'b0, 1'b1, 8'd2};
        vecs[13] = '{3'b110, 2'b01, 1'b1, 8'd1, 8'd1, 1'b0, 1'b0, 8'd2};
        vecs[14] = '{3'b000, 2'b01, 1'b0, 8'd0, 8'd1, 1'b0, 1'b1, 8'd3};
        vecs[15] = '{3'b000, 2'b01, 1'b0, 8'd0, 8'd1, 1'b0, 1'b1, 8'd4};
        vecs[16] = '{3'b101, 2'b01, 1'b0, 8'd0, 8'd1, 1'b0, 1'b1, 8'd5};
        vecs[17] = '{3'b011, 2'b01, 1'b0, 8'd0, 8'd1, 1'b0, 1'b1, 8'd6};
        vecs[18] = '{3'b010, 2'b11, 1'b1, 8'd1, 8'd1, 1'b0, 1'b0, 8'd6};
        vecs[19] = '{3'b100, 2'b00, 1'b1, 8'd1, 8'd2, 1'b0, 1'b0, 8'd6};
        vecs[20] = '{3'b010, 2'b11, 1'b1, 8'd1, 8'd2, 1'b1, 1'b0, 8'd7};
        vecs[21] = '{3'b100, 2'b00, 1'b1, 8'd1, 8'd3, 1'b0, 1'b0, 8'd7};

        // Reset state
        #3;
        check_all_zero("reset");

        // Table: normal sequence, out-of-order, illegal codes, relock
        do_reset(3'b100);
        for (int i = 0; i < 22; i++) begin
            step(vecs[i].lamps);
            check($sformatf("v%0d phase", i),       32'(phase),       32'(vecs[i].phase));
            check($sformatf("v%0d phase_valid", i), 32'(phase_valid), 32'(vecs[i].valid));
            check($sformatf("v%0d dwell", i),       32'(dwell),       32'(vecs[i].dwell));
            check($sformatf("v%0d cycle_count", i), 32'(cycle_count), 32'(vecs[i].cyc));
            check($sformatf("v%0d seq_err", i),     32'(seq_err),     32'(vecs[i].seq));
            check($sformatf("v%0d illegal_err", i), 32'(illegal_err), 32'(vecs[i].ill));
            check($sformatf("v%0d timeout_err", i), 32'(timeout_err), 0);
            check($sformatf("v%0d err_count", i),   32'(err_count),   32'(vecs[i].errc));
        end

        // Hold red: timeout once at edge 17, dwell saturates at 255
        do_reset(3'b100);
        to_pulses = 0;
        to_edge   = 0;
        for (int e = 1; e <= 300; e++) begin
            step(3'b100);
            if (timeout_err) begin
                to_pulses++;
                to_edge = e;
            end
            if (e == 16) check("dwell at 16", 32'(dwell), 16);
            if (e == 20) begin
                check("timeout pulses by 20", 32'(to_pulses), 32'(TO_EXP));
                check("timeout edge", 32'(to_edge), (TO_EXP == 1) ? 17 : 0);
                check("timeout err_count", 32'(err_count), 32'(TO_EXP));
                check("dwell at 20", 32'(dwell), 20);
            end
            if (e == 255) check("dwell at 255", 32'(dwell), 255);
        end
        check("dwell saturated", 32'(dwell), 255);
        check("timeout pulses total", 32'(to_pulses), 32'(TO_EXP));
        check("timeout keeps lock", 32'({phase_valid, phase}), 32'(3'b100));

        // 300 alternating out-of-order codes: err_count saturates at 255
        do_reset(3'b100);
        step(3'b100);
        seq_pulses = 0;
        for (int k = 1; k <= 300; k++) begin
            step((k % 2 == 1) ? 3'b001 : 3'b100);
            if (seq_err) seq_pulses++;
            if (k == 254) check("err_count 254", 32'(err_count), 254);
            if (k == 255) check("err_count 255", 32'(err_count), 255);
        end
        check("err_count saturated", 32'(err_count), 255);
        check("seq pulses", 32'(seq_pulses), 300);
        check("sat cycle_count", 32'(cycle_count), 0);

        // 257 full cycles: cycle_count wraps to 1
        do_reset(3'b100);
        step(3'b100);
        for (int c = 1; c <= 257; c++) begin
            step(3'b110);
            step(3'b001);
            step(3'b010);
            step(3'b100);
            if (c == 255) check("cycle_count 255", 32'(cycle_count), 255);
            if (c == 256) check("cycle_count wrap 0", 32'(cycle_count), 0);
        end
        check("cycle_count wrap 1", 32'(cycle_count), 1);
        check("wrap err_count", 32'(err_count), 0);

        // Reset mid-green clears outputs immediately; relock on amber
        step(3'b110);
        step(3'b001);
        step(3'b001);
        check("pre-reset phase", 32'(phase), 2);
        check("pre-reset cycle_count", 32'(cycle_count), 1);
        rst = 1'b1;
        #1;
        check_all_zero("async rst");
        @(negedge clk);
        lamps = 3'b010;
        rst   = 1'b0;
        @(posedge clk);
        #1;
        check("relock phase", 32'(phase), 3);
        check("relock valid", 32'(phase_valid), 1);
        check("relock dwell", 32'(dwell), 1);
        check("relock errs", 32'({seq_err, illegal_err, timeout_err}), 0);
        check("relock err_count", 32'(err_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
